// File: rtl/fifo_sram_sync_fwft.sv
// rtl/fifo_sram_sync_fwft.sv - single-clock SRAM FIFO with 2-entry skid buffer for first-word-fall-through reads
module fifo_sram_sync_fwft #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Skid state encodes how many entries sit in the output buffer.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } skid_state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_mem_q;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_count;
    logic             r_inflight;
    skid_state_t      r_state;
    logic [WIDTH-1:0] r_skid0;
    logic [WIDTH-1:0] r_skid1;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_full;
    logic             w_wr_acc;
    logic             w_pop;
    logic             w_sram_has;
    logic [1:0]       w_occ;
    logic [2:0]       w_slots;
    logic [2:0]       w_slot_limit;
    logic             w_issue;
    logic             w_land;
    logic [AW-1:0]    w_wr_addr;
    logic [AW-1:0]    w_rd_addr;

    assign w_full       = (r_count == PW'(DEPTH));
    assign w_wr_acc     = wr_en & ~w_full & ~flush;
    assign w_pop        = rd_en & r_rd_valid & ~flush;
    assign w_sram_has   = (r_wr_ptr != r_rd_ptr);
    assign w_wr_addr    = r_wr_ptr[AW-1:0];
    assign w_rd_addr    = r_rd_ptr[AW-1:0];

    // Skid occupancy as a number, used by the read-issue throttle.
    always_comb begin
        w_occ = 2'd0;
        case (r_state)
            S0:      w_occ = 2'd0;
            S1:      w_occ = 2'd1;
            S2:      w_occ = 2'd2;
            default: w_occ = 2'd0;
        endcase
    end

    // Issue only if the landing word is guaranteed a free skid slot next cycle.
    assign w_slots      = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_slot_limit = 3'd2 + {2'b00, w_pop};
    assign w_issue      = ~flush & w_sram_has & (w_slots < w_slot_limit);
    assign w_land       = r_inflight & ~flush;

    // SRAM array write port; no reset so it maps onto a RAM macro.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    // SRAM synchronous read port: one-cycle latency into r_mem_q.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_mem_q <= r_mem[w_rd_addr];
        end
    end

    // Write/read pointers, occupancy count and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count    <= r_count + PW'(w_wr_acc) - PW'(w_pop);
            r_inflight <= w_issue;
        end
    end

    // Output skid buffer FSM with registered head data and valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S0;
            r_skid0    <= '0;
            r_skid1    <= '0;
            r_rd_valid <= 1'b0;
        end else if (flush) begin
            r_state    <= S0;
            r_skid0    <= '0;
            r_skid1    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                S0: begin
                    if (w_land) begin
                        r_skid0    <= r_mem_q;
                        r_state    <= S1;
                        r_rd_valid <= 1'b1;
                    end
                end
                S1: begin
                    if (w_land && !w_pop) begin
                        r_skid1    <= r_mem_q;
                        r_state    <= S2;
                        r_rd_valid <= 1'b1;
                    end else if (w_land && w_pop) begin
                        r_skid0    <= r_mem_q;
                        r_state    <= S1;
                        r_rd_valid <= 1'b1;
                    end else if (w_pop) begin
                        r_state    <= S0;
                        r_rd_valid <= 1'b0;
                    end
                end
                S2: begin
                    if (w_pop) begin
                        r_skid0 <= r_skid1;
                        if (w_land) begin
                            r_skid1 <= r_mem_q;
                            r_state <= S2;
                        end else begin
                            r_state <= S1;
                        end
                        r_rd_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S0;
                    r_rd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; illegal attempts set them, only reset/flush clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !r_rd_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign wr_full      = w_full;
    assign rd_data      = r_skid0;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign almost_full  = (r_count >= PW'(AF_LEVEL));
    assign almost_empty = (r_count <= PW'(AE_LEVEL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sram_sync_fwft.sv
// tb/tb_fifo_sram_sync_fwft.sv - directed and random checks of fifo_sram_sync_fwft against a queue model
module tb_fifo_sram_sync_fwft;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             wr_full;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    fifo_sram_sync_fwft #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [31:0] mq[$];
    int         tq[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    string      phase = "reset";

    // Head is visible once it was written at least two edges ago.
    function automatic logic m_valid();
        if (mq.size() == 0) return 1'b0;
        return (cyc - tq[0]) >= 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 64'(count), 64'(mq.size()));
        chk("wr_full", 64'(wr_full), 64'(mq.size() == DEPTH));
        chk("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - 2));
        chk("almost_empty", 64'(almost_empty), 64'(mq.size() <= 2));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("rd_valid", 64'(rd_valid), 64'(m_valid()));
        if (m_valid()) chk("rd_data", 64'(rd_data), 64'(mq[0]));
    endtask

    // One clock: drive inputs, advance the model across the edge, check outputs.
    task automatic step(input logic w, input logic [31:0] d, input logic r, input logic f);
        logic full_b;
        logic valid_b;
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        full_b  = (mq.size() == DEPTH);
        valid_b = m_valid();
        @(posedge clk);
        cyc++;
        if (f) begin
            mq.delete(); tq.delete();
            m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (w && full_b) m_ovf = 1'b1;
            if (r && !valid_b) m_unf = 1'b1;
            if (r && valid_b) begin
                void'(mq.pop_front());
                void'(tq.pop_front());
            end
            if (w && !full_b) begin
                mq.push_back(d);
                tq.push_back(cyc);
            end
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        check_all();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        chk("rst_rd_data", 64'(rd_data), 64'h0);

        phase = "fill";
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_full", 64'(wr_full), 64'h1);
        chk("fill_count", 64'(count), 64'(DEPTH));
        phase = "drain";
        for (int i = 0; i < DEPTH; i++) begin
            chk("no_bubble", 64'(rd_valid), 64'h1);
            chk("order", 64'(rd_data), 64'(i));
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain_valid", 64'(rd_valid), 64'h0);
        chk("drain_count", 64'(count), 64'h0);

        phase = "latency";
        step(1'b1, 32'hA5, 1'b0, 1'b0);
        chk("lat_k", 64'(rd_valid), 64'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("lat_k1", 64'(rd_valid), 64'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("lat_k2_valid", 64'(rd_valid), 64'h1);
        chk("lat_k2_data", 64'(rd_data), 64'hA5);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        phase = "random";
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);

        phase = "simul_full";
        for (int i = 0; i < 2 * DEPTH && mq.size() < DEPTH; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_full", 64'(count), 64'(DEPTH));
        step(1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("simul_count15", 64'(count), 64'(DEPTH - 1));
        chk("simul_ovf", 64'(overflow), 64'h1);
        phase = "simul_mid";
        for (int i = 0; i < DEPTH && mq.size() > 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h1234, 1'b1, 1'b0);
        chk("simul_count5", 64'(count), 64'h5);

        phase = "underflow";
        for (int i = 0; i < 4 * DEPTH && mq.size() > 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("unf_set", 64'(underflow), 64'h1);
        chk("unf_count", 64'(count), 64'h0);
        chk("unf_valid", 64'(rd_valid), 64'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("unf_flushed", 64'(underflow), 64'h0);
        chk("ovf_flushed", 64'(overflow), 64'h0);

        phase = "flush_race";
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b1);
        chk("fr_count", 64'(count), 64'h0);
        chk("fr_valid", 64'(rd_valid), 64'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            chk("fr_stale", 64'(rd_valid), 64'h0);
        end

        phase = "async_rst";
        for (int i = 0; i < 12; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_count", 64'(count), 64'h9);
        rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        mq.delete(); tq.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
        check_all();
        chk("arst_rd_data", 64'(rd_data), 64'h0);
        rst = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        step(1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_valid", 64'(rd_valid), 64'h1);
        chk("post_rst_data", 64'(rd_data), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
